// File: rtl/control_fsm_if.sv
// Control/handshake bundle between the sequencing controller and the datapath/bus side.
// master = controller, slave = datapath, memory and mul/div side.
interface control_fsm_if;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned SR2_W   = 1;
    localparam int unsigned RFSRC_W = 3;
    localparam int unsigned JTGT_W  = 2;

    logic               run;
    logic [OPC_W-1:0]   opcode;
    logic               funct7_b0;
    logic               branch_taken;
    logic               fetch_req;
    logic               fetch_ack;
    logic               ir_load;
    logic               mem_req;
    logic               mem_we;
    logic               mem_ack;
    logic               md_start;
    logic               md_done;
    logic [SR2_W-1:0]   sr2_src;
    logic [RFSRC_W-1:0] regfile_src;
    logic [JTGT_W-1:0]  jmp_target_src;
    logic               regfile_wr;
    logic               pc_wr;
    logic               jump;
    logic               illegal;
    logic               bus_fault;
    logic               trap;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  run, opcode, funct7_b0, branch_taken, fetch_ack, mem_ack, md_done,
        output fetch_req, ir_load, mem_req, mem_we, md_start, sr2_src, regfile_src,
               jmp_target_src, regfile_wr, pc_wr, jump, illegal, bus_fault, trap, state_o
    );

    modport slave (
        output run, opcode, funct7_b0, branch_taken, fetch_ack, mem_ack, md_done,
        input  fetch_req, ir_load, mem_req, mem_we, md_start, sr2_src, regfile_src,
               jmp_target_src, regfile_wr, pc_wr, jump, illegal, bus_fault, trap, state_o
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV32I sequencing controller: fetch/decode/execute FSM with bus and
// mul/div handshakes, illegal-opcode and bus-timeout traps.
package global_pkg;
    typedef enum logic {
        I_IMM_SRC = 1'b0,
        REG_SRC   = 1'b1
    } sr2_src_t;

    typedef enum logic [2:0] {
        ALU_INPUT = 3'd0,
        U_IMM_SRC = 3'd1,
        AUIPC_SRC = 3'd2,
        LOAD_SRC  = 3'd3,
        PC_SRC    = 3'd4
    } regfile_src_t;

    typedef enum logic [1:0] {
        J_IMM = 2'd0,
        I_IMM = 2'd1,
        B_IMM = 2'd2
    } jmp_target_src_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
endpackage

module control_fsm
    import global_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          ENABLE_M    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.master bus
);
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM     = 3'd4,
        S_WAIT_MD = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    state_t           state, state_next;
    logic [OPC_W-1:0] opcode_q;
    logic             f7_q;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             cnt_inc;
    logic             timeout_hit;

    // Timeout only fires on the last allowed cycle; MEM_TIMEOUT=0 never fires.
    assign timeout_hit = (MEM_TIMEOUT != 32'd0) && (cnt == CNT_W'(TO_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RESET;
            opcode_q <= '0;
            f7_q     <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == S_DECODE) begin
                opcode_q <= bus.opcode;
                f7_q     <= bus.funct7_b0;
            end
        end
    end

    // Counter restarts whenever the state changes.
    always_comb begin
        cnt_next = cnt;
        if (state_next != state) begin
            cnt_next = '0;
        end else if (cnt_inc) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next         = state;
        cnt_inc            = 1'b0;
        bus.fetch_req      = 1'b0;
        bus.ir_load        = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_we         = 1'b0;
        bus.md_start       = 1'b0;
        bus.regfile_wr     = 1'b0;
        bus.pc_wr          = 1'b0;
        bus.jump           = 1'b0;
        bus.illegal        = 1'b0;
        bus.bus_fault      = 1'b0;
        bus.trap           = 1'b0;
        bus.sr2_src        = I_IMM_SRC;
        bus.regfile_src    = ALU_INPUT;
        bus.jmp_target_src = J_IMM;
        bus.state_o        = state;

        if (state == S_EXEC || state == S_MEM || state == S_WAIT_MD) begin
            if (opcode_q == OPC_OP) bus.sr2_src = REG_SRC;
            case (opcode_q)
                OPC_LUI:                         bus.regfile_src = U_IMM_SRC;
                OPC_AUIPC:                       bus.regfile_src = AUIPC_SRC;
                OPC_LOAD:                        bus.regfile_src = LOAD_SRC;
                OPC_JAL, OPC_JALR, OPC_BRANCH:   bus.regfile_src = PC_SRC;
                default:                         ;
            endcase
            case (opcode_q)
                OPC_JALR:   bus.jmp_target_src = I_IMM;
                OPC_BRANCH: bus.jmp_target_src = B_IMM;
                default:    ;
            endcase
        end

        case (state)
            S_RESET: state_next = S_FETCH;

            S_FETCH: begin
                bus.fetch_req = bus.run;
                if (bus.run) begin
                    if (bus.fetch_ack) begin
                        bus.ir_load = 1'b1;
                        state_next  = S_DECODE;
                    end else begin
                        cnt_inc = 1'b1;
                        if (timeout_hit) begin
                            bus.bus_fault = 1'b1;
                            state_next    = S_TRAP;
                        end
                    end
                end
            end

            S_DECODE: state_next = S_EXEC;

            S_EXEC: begin
                case (opcode_q)
                    OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                        bus.regfile_wr = 1'b1;
                        bus.pc_wr      = 1'b1;
                        state_next     = S_FETCH;
                    end
                    OPC_OP: begin
                        if (ENABLE_M && f7_q) begin
                            bus.md_start = 1'b1;
                            state_next   = S_WAIT_MD;
                        end else begin
                            bus.regfile_wr = 1'b1;
                            bus.pc_wr      = 1'b1;
                            state_next     = S_FETCH;
                        end
                    end
                    OPC_JAL, OPC_JALR: begin
                        bus.regfile_wr = 1'b1;
                        bus.jump       = 1'b1;
                        bus.pc_wr      = 1'b1;
                        state_next     = S_FETCH;
                    end
                    OPC_BRANCH: begin
                        bus.pc_wr  = 1'b1;
                        bus.jump   = bus.branch_taken;
                        state_next = S_FETCH;
                    end
                    OPC_LOAD, OPC_STORE: state_next = S_MEM;
                    default: begin
                        bus.illegal = 1'b1;
                        state_next  = S_TRAP;
                    end
                endcase
            end

            // An ack on the timeout cycle completes normally.
            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = (opcode_q == OPC_STORE);
                if (bus.mem_ack) begin
                    bus.pc_wr      = 1'b1;
                    bus.regfile_wr = (opcode_q == OPC_LOAD);
                    state_next     = S_FETCH;
                end else begin
                    cnt_inc = 1'b1;
                    if (timeout_hit) begin
                        bus.bus_fault = 1'b1;
                        state_next    = S_TRAP;
                    end
                end
            end

            S_WAIT_MD: begin
                if (bus.md_done) begin
                    bus.regfile_wr = 1'b1;
                    bus.pc_wr      = 1'b1;
                    state_next     = S_FETCH;
                end
            end

            S_TRAP: bus.trap = 1'b1;

            default: state_next = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: scoreboard of expected completion strobes/selectors,
// plus timing, timeout, trap and asynchronous-reset checks.
module tb_control_fsm;
    import global_pkg::*;

    typedef struct packed {
        logic       rf_wr;
        logic [2:0] rf_src;
        logic       jump;
        logic [1:0] jt;
        logic       sr2;
        logic       we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int done_k, n_req, n_start, n_fault, n_early;

    always #5 clk = ~clk;

    control_fsm_if ifa ();
    control_fsm_if ifb ();

    assign ifb.run          = ifa.run;
    assign ifb.opcode       = ifa.opcode;
    assign ifb.funct7_b0    = ifa.funct7_b0;
    assign ifb.branch_taken = ifa.branch_taken;
    assign ifb.fetch_ack    = ifa.fetch_ack;
    assign ifb.mem_ack      = ifa.mem_ack;
    assign ifb.md_done      = ifa.md_done;

    control_fsm #(.MEM_TIMEOUT(4), .ENABLE_M(1'b1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    control_fsm #(.MEM_TIMEOUT(16), .ENABLE_M(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic rf_wr, input regfile_src_t src, input logic jmp,
                                input jmp_target_src_t jt, input sr2_src_t s2, input logic we);
        exp_t e;
        e.rf_wr = rf_wr; e.rf_src = src; e.jump = jmp; e.jt = jt; e.sr2 = s2; e.we = we;
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Fetch (after fetch_wait stalled cycles), decode, and stop in the EXEC cycle.
    task automatic issue(input logic [6:0] opc, input logic f7, input logic bt, input int fetch_wait);
        for (int w = 0; w < fetch_wait; w++) begin
            next_cycle();
            ifa.mem_ack = 1'b0; ifa.md_done = 1'b0; ifa.run = 1'b1; ifa.fetch_ack = 1'b0;
            #1;
            chk("fetch_wait_req", 32'(ifa.fetch_req), 32'd1);
            chk("fetch_wait_fault", 32'(ifa.bus_fault), 32'd0);
        end
        next_cycle();
        ifa.mem_ack = 1'b0; ifa.md_done = 1'b0; ifa.run = 1'b1; ifa.fetch_ack = 1'b1;
        #1;
        chk("fetch_state", 32'(ifa.state_o), 32'd1);
        chk("fetch_req", 32'(ifa.fetch_req), 32'd1);
        chk("ir_load", 32'(ifa.ir_load), 32'd1);
        chk("fetch_no_fault", 32'(ifa.bus_fault), 32'd0);
        next_cycle();
        ifa.fetch_ack = 1'b0; ifa.opcode = opc; ifa.funct7_b0 = f7;
        #1;
        chk("decode_state", 32'(ifa.state_o), 32'd2);
        chk("decode_ir_load", 32'(ifa.ir_load), 32'd0);
        next_cycle();
        ifa.opcode = 7'h7F; ifa.funct7_b0 = ~f7; ifa.branch_taken = bt;
        #1;
        chk("exec_state", 32'(ifa.state_o), 32'd3);
    endtask

    // From EXEC (k=0) until pc_wr or trap; acks arrive at cycle ack_at.
    task automatic finish_instr(input int ack_at, input bit early, input int budget,
                                output int dk, output int nr, output int ns, output int nf, output int ne);
        exp_t e;
        dk = -1; nr = 0; ns = 0; nf = 0; ne = 0;
        for (int k = 0; k < budget; k++) begin
            if (k > 0) next_cycle();
            ifa.mem_ack = (k == ack_at);
            ifa.md_done = (k == ack_at) || (early && k == 0);
            #1;
            nr += int'(ifa.mem_req);
            ns += int'(ifa.md_start);
            nf += int'(ifa.bus_fault);
            if (ifa.regfile_wr && !ifa.pc_wr) ne++;
            if (ifa.trap) break;
            if (ifa.pc_wr) begin
                dk = k;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_regfile_wr", 32'(ifa.regfile_wr), 32'(e.rf_wr));
                    chk("done_regfile_src", 32'(ifa.regfile_src), 32'(e.rf_src));
                    chk("done_jump", 32'(ifa.jump), 32'(e.jump));
                    chk("done_jmp_target_src", 32'(ifa.jmp_target_src), 32'(e.jt));
                    chk("done_sr2_src", 32'(ifa.sr2_src), 32'(e.sr2));
                    chk("done_mem_we", 32'(ifa.mem_we), 32'(e.we));
                end
                break;
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.run = 1'b1; ifa.opcode = '0; ifa.funct7_b0 = 1'b0; ifa.branch_taken = 1'b0;
        ifa.fetch_ack = 1'b0; ifa.mem_ack = 1'b0; ifa.md_done = 1'b0;
        repeat (3) next_cycle();
        #1;
        chk("rst_state", 32'(ifa.state_o), 32'd0);
        chk("rst_fetch_req", 32'(ifa.fetch_req), 32'd0);
        chk("rst_pc_wr", 32'(ifa.pc_wr), 32'd0);
        chk("rst_trap", 32'(ifa.trap), 32'd0);
        chk("rst_sr2_src", 32'(ifa.sr2_src), 32'(I_IMM_SRC));
        chk("rst_regfile_src", 32'(ifa.regfile_src), 32'(ALU_INPUT));
        chk("rst_jmp_target_src", 32'(ifa.jmp_target_src), 32'(J_IMM));
        next_cycle();
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("post_rst_state", 32'(ifa.state_o), 32'd0);

        // MUL: dispatched to mul/div on A, plain OP on B (ENABLE_M=0)
        sb.push_back(mk(1'b1, ALU_INPUT, 1'b0, J_IMM, REG_SRC, 1'b0));
        issue(7'h33, 1'b1, 1'b0, 0);
        chk("b_mul_pc_wr", 32'(ifb.pc_wr), 32'd1);
        chk("b_mul_regfile_wr", 32'(ifb.regfile_wr), 32'd1);
        chk("b_mul_md_start", 32'(ifb.md_start), 32'd0);
        chk("b_mul_sr2_src", 32'(ifb.sr2_src), 32'(REG_SRC));
        rst_b = 1'b1;
        finish_instr(5, 1'b1, 10, done_k, n_req, n_start, n_fault, n_early);
        chk("mul_done_cycle", 32'(done_k), 32'd5);
        chk("mul_md_start_count", 32'(n_start), 32'd1);
        chk("mul_early_wr", 32'(n_early), 32'd0);

        // ADDI
        sb.push_back(mk(1'b1, ALU_INPUT, 1'b0, J_IMM, I_IMM_SRC, 1'b0));
        issue(7'h13, 1'b0, 1'b0, 0);
        finish_instr(-1, 1'b0, 4, done_k, n_req, n_start, n_fault, n_early);
        chk("addi_done_cycle", 32'(done_k), 32'd0);

        // LW with ack on the 4th MEM cycle, which is also the timeout cycle
        sb.push_back(mk(1'b1, LOAD_SRC, 1'b0, J_IMM, I_IMM_SRC, 1'b0));
        issue(7'h03, 1'b0, 1'b0, 0);
        finish_instr(4, 1'b0, 8, done_k, n_req, n_start, n_fault, n_early);
        chk("lw_done_cycle", 32'(done_k), 32'd4);
        chk("lw_mem_req_cycles", 32'(n_req), 32'd4);
        chk("lw_no_fault", 32'(n_fault), 32'd0);
        chk("lw_early_wr", 32'(n_early), 32'd0);

        // SW
        sb.push_back(mk(1'b0, ALU_INPUT, 1'b0, J_IMM, I_IMM_SRC, 1'b1));
        issue(7'h23, 1'b0, 1'b0, 0);
        finish_instr(1, 1'b0, 6, done_k, n_req, n_start, n_fault, n_early);
        chk("sw_done_cycle", 32'(done_k), 32'd1);
        chk("sw_mem_req_cycles", 32'(n_req), 32'd1);

        // BEQ taken, then not taken
        sb.push_back(mk(1'b0, PC_SRC, 1'b1, B_IMM, I_IMM_SRC, 1'b0));
        issue(7'h63, 1'b0, 1'b1, 0);
        finish_instr(-1, 1'b0, 4, done_k, n_req, n_start, n_fault, n_early);
        chk("beq_t_done_cycle", 32'(done_k), 32'd0);
        sb.push_back(mk(1'b0, PC_SRC, 1'b0, B_IMM, I_IMM_SRC, 1'b0));
        issue(7'h63, 1'b0, 1'b0, 0);
        finish_instr(-1, 1'b0, 4, done_k, n_req, n_start, n_fault, n_early);
        chk("beq_nt_done_cycle", 32'(done_k), 32'd0);

        // JAL, JALR, AUIPC, plain OP
        sb.push_back(mk(1'b1, PC_SRC, 1'b1, J_IMM, I_IMM_SRC, 1'b0));
        issue(7'h6F, 1'b0, 1'b0, 0);
        finish_instr(-1, 1'b0, 4, done_k, n_req, n_start, n_fault, n_early);
        sb.push_back(mk(1'b1, PC_SRC, 1'b1, I_IMM, I_IMM_SRC, 1'b0));
        issue(7'h67, 1'b0, 1'b0, 0);
        finish_instr(-1, 1'b0, 4, done_k, n_req, n_start, n_fault, n_early);
        sb.push_back(mk(1'b1, AUIPC_SRC, 1'b0, J_IMM, I_IMM_SRC, 1'b0));
        issue(7'h17, 1'b0, 1'b0, 0);
        finish_instr(-1, 1'b0, 4, done_k, n_req, n_start, n_fault, n_early);
        sb.push_back(mk(1'b1, ALU_INPUT, 1'b0, J_IMM, REG_SRC, 1'b0));
        issue(7'h33, 1'b0, 1'b0, 0);
        finish_instr(-1, 1'b0, 4, done_k, n_req, n_start, n_fault, n_early);
        chk("add_done_cycle", 32'(done_k), 32'd0);
        chk("add_md_start_count", 32'(n_start), 32'd0);

        // Fetch stall: counter reaches 2, freezes while run=0, ack on the last allowed cycle
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            ifa.run = 1'b1; ifa.fetch_ack = 1'b0; ifa.mem_ack = 1'b0; ifa.md_done = 1'b0;
            #1;
            chk("stall_fetch_req", 32'(ifa.fetch_req), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            ifa.run = 1'b0;
            #1;
            chk("norun_fetch_req", 32'(ifa.fetch_req), 32'd0);
            chk("norun_fault", 32'(ifa.bus_fault), 32'd0);
            chk("norun_state", 32'(ifa.state_o), 32'd1);
        end
        sb.push_back(mk(1'b1, U_IMM_SRC, 1'b0, J_IMM, I_IMM_SRC, 1'b0));
        issue(7'h37, 1'b0, 1'b0, 1);
        finish_instr(-1, 1'b0, 4, done_k, n_req, n_start, n_fault, n_early);
        chk("lui_done_cycle", 32'(done_k), 32'd0);

        // Reset asserted mid-MEM
        issue(7'h03, 1'b0, 1'b0, 0);
        next_cycle();
        ifa.mem_ack = 1'b0;
        #1;
        chk("mid_mem_req", 32'(ifa.mem_req), 32'd1);
        #1 rst_a = 1'b1;
        #1;
        chk("async_rst_mem_req", 32'(ifa.mem_req), 32'd0);
        chk("async_rst_state", 32'(ifa.state_o), 32'd0);
        next_cycle();
        next_cycle();
        rst_a = 1'b0;
        #1;
        chk("rst_release_state", 32'(ifa.state_o), 32'd0);
        next_cycle();
        #1;
        chk("rst_then_fetch", 32'(ifa.state_o), 32'd1);

        // LOAD with no ack: fault on 4th MEM cycle, then held in TRAP
        issue(7'h03, 1'b0, 1'b0, 0);
        finish_instr(-1, 1'b0, 8, done_k, n_req, n_start, n_fault, n_early);
        chk("to_no_done", 32'(done_k), 32'hFFFF_FFFF);
        chk("to_mem_req_cycles", 32'(n_req), 32'd4);
        chk("to_fault_pulses", 32'(n_fault), 32'd1);
        chk("to_trap", 32'(ifa.trap), 32'd1);
        chk("to_trap_state", 32'(ifa.state_o), 32'd6);
        chk("to_trap_mem_req", 32'(ifa.mem_req), 32'd0);
        next_cycle();
        ifa.fetch_ack = 1'b1; ifa.mem_ack = 1'b1;
        #1;
        chk("trap_holds", 32'(ifa.trap), 32'd1);
        chk("trap_fetch_req", 32'(ifa.fetch_req), 32'd0);
        chk("trap_pc_wr", 32'(ifa.pc_wr), 32'd0);

        // Illegal opcode
        rst_a = 1'b1;
        #1;
        chk("rst_clears_trap", 32'(ifa.trap), 32'd0);
        next_cycle();
        rst_a = 1'b0;
        issue(7'h7F, 1'b0, 1'b0, 0);
        chk("illegal_pulse", 32'(ifa.illegal), 32'd1);
        chk("illegal_pc_wr", 32'(ifa.pc_wr), 32'd0);
        chk("illegal_regfile_wr", 32'(ifa.regfile_wr), 32'd0);
        next_cycle();
        #1;
        chk("illegal_trap", 32'(ifa.trap), 32'd1);
        chk("illegal_one_cycle", 32'(ifa.illegal), 32'd0);
        chk("illegal_trap_state", 32'(ifa.state_o), 32'd6);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
